// File: rtl/bytes_to_dibits_crc32.sv
// Byte-to-RMII-dibit serializer with running reflected CRC-32; optional FCS append under FCS_APPEND_EN.
// Latency: byte strobed at edge N drives dibits N+1..N+4; one pending slot, a strobe with the slot full is dropped.
module bytes_to_dibits_crc32 #(
    parameter int          BYTE_LEN = 8,
    parameter logic [31:0] CRC_POLY = 32'hEDB88320,
    parameter logic [31:0] CRC_INIT = 32'hFFFFFFFF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inclk,
    input  logic [BYTE_LEN-1:0] in,
    input  logic                done_in,
    output logic [1:0]          out,
    output logic                outclk,
    output logic                idle,
    output logic                done_out,
    output logic [31:0]         crc
);

`ifdef FCS_APPEND_EN
    typedef enum logic [1:0] {IDLE, SHIFT, FCS, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    state_t              state_q, state_d;
    logic [BYTE_LEN-1:0] sh_q, sh_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [BYTE_LEN-1:0] pend_q, pend_d;
    logic                pend_vld_q, pend_vld_d;
    logic                pend_nxt_q, pend_nxt_d;
    logic                done_flag_q, done_flag_d;
    logic [31:0]         lfsr_q, lfsr_d;
    logic [31:0]         crc_q, crc_d;
    logic [1:0]          out_q, out_d;
    logic                outclk_q, outclk_d;
    logic                done_out_q, done_out_d;
    logic                idle_q, idle_d;
`ifdef FCS_APPEND_EN
    logic [3:0]          fcs_cnt_q, fcs_cnt_d;
`endif

    logic                load_ok, use_pend, use_in;
    logic [BYTE_LEN-1:0] load_byte;

    function automatic logic [31:0] crc_step(input logic [31:0] s, input logic b);
        logic fb;
        fb = s[0] ^ b;
        return (s >> 1) ^ (fb ? CRC_POLY : 32'h0);
    endfunction

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        pend_vld_d  = pend_vld_q;
        pend_nxt_d  = pend_nxt_q;
        done_flag_d = done_flag_q | done_in;
        lfsr_d      = lfsr_q;
        out_d       = 2'b00;
        outclk_d    = 1'b0;
        done_out_d  = 1'b0;
`ifdef FCS_APPEND_EN
        fcs_cnt_d   = fcs_cnt_q;
`endif

        // Only data dibits feed the LFSR; FCS dibits leave it frozen.
        if (outclk_q && state_q == SHIFT)
            lfsr_d = crc_step(crc_step(lfsr_q, out_q[0]), out_q[1]);

        // A pending byte captured after done_in waits for the next frame.
        load_ok   = (state_q == IDLE) || (state_q == SHIFT && cnt_q == 2'd3);
        use_pend  = load_ok && pend_vld_q && !pend_nxt_q;
        use_in    = load_ok && !pend_vld_q && inclk && !done_flag_q;
        load_byte = use_pend ? pend_q : in;

        if (use_pend)
            pend_vld_d = 1'b0;
        if (inclk && !pend_vld_q && !use_in) begin
            pend_d     = in;
            pend_vld_d = 1'b1;
            pend_nxt_d = done_flag_q || (state_q == DONE)
`ifdef FCS_APPEND_EN
                         || (state_q == FCS)
`endif
                         ;
        end

        case (state_q)
            IDLE, SHIFT: begin
                if (state_q == SHIFT && cnt_q != 2'd3) begin
                    cnt_d    = cnt_q + 2'd1;
                    sh_d     = sh_q >> 2;
                    out_d    = sh_q[3:2];
                    outclk_d = 1'b1;
                end else if (use_pend || use_in) begin
                    state_d  = SHIFT;
                    cnt_d    = 2'd0;
                    sh_d     = load_byte;
                    out_d    = load_byte[1:0];
                    outclk_d = 1'b1;
                end else if (done_flag_q || done_in) begin
`ifdef FCS_APPEND_EN
                    if (state_q == SHIFT) begin
                        state_d   = FCS;
                        fcs_cnt_d = 4'd0;
                        out_d     = ~lfsr_d[1:0];
                        outclk_d  = 1'b1;
                    end else begin
                        state_d    = DONE;
                        done_out_d = 1'b1;
                    end
`else
                    state_d    = DONE;
                    done_out_d = 1'b1;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
`ifdef FCS_APPEND_EN
            FCS: begin
                if (fcs_cnt_q == 4'd15) begin
                    state_d    = DONE;
                    done_out_d = 1'b1;
                end else begin
                    fcs_cnt_d = fcs_cnt_q + 4'd1;
                    out_d     = crc_q[{fcs_cnt_d, 1'b0} +: 2];
                    outclk_d  = 1'b1;
                end
            end
`endif
            DONE: begin
                state_d     = IDLE;
                lfsr_d      = CRC_INIT;
                done_flag_d = done_in;
                pend_nxt_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        crc_d  = ~lfsr_d;
        idle_d = (state_d == IDLE) && !pend_vld_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            cnt_q       <= 2'd0;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            pend_nxt_q  <= 1'b0;
            done_flag_q <= 1'b0;
            lfsr_q      <= CRC_INIT;
            crc_q       <= 32'h0;
            out_q       <= 2'b00;
            outclk_q    <= 1'b0;
            done_out_q  <= 1'b0;
            idle_q      <= 1'b1;
`ifdef FCS_APPEND_EN
            fcs_cnt_q   <= 4'd0;
`endif
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            pend_nxt_q  <= pend_nxt_d;
            done_flag_q <= done_flag_d;
            lfsr_q      <= lfsr_d;
            crc_q       <= crc_d;
            out_q       <= out_d;
            outclk_q    <= outclk_d;
            done_out_q  <= done_out_d;
            idle_q      <= idle_d;
`ifdef FCS_APPEND_EN
            fcs_cnt_q   <= fcs_cnt_d;
`endif
        end
    end

    assign out      = out_q;
    assign outclk   = outclk_q;
    assign idle     = idle_q;
    assign done_out = done_out_q;
    assign crc      = crc_q;

endmodule

// File: tb/tb_bytes_to_dibits_crc32.sv
// Directed bench for bytes_to_dibits_crc32: table of frames with known CRC-32 values plus hand sequences.
module tb_bytes_to_dibits_crc32;

    logic        clk;
    logic        reset;
    logic        inclk;
    logic [7:0]  in;
    logic        done_in;
    logic [1:0]  out;
    logic        outclk;
    logic        idle;
    logic        done_out;
    logic [31:0] crc;

    int tests;
    int fails;

    bytes_to_dibits_crc32 dut (
        .clk      (clk),
        .reset    (reset),
        .inclk    (inclk),
        .in       (in),
        .done_in  (done_in),
        .out      (out),
        .outclk   (outclk),
        .idle     (idle),
        .done_out (done_out),
        .crc      (crc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [71:0] data;   // bytes right-aligned, first byte most significant
        int          len;
        logic [31:0] exp_crc;
    } frame_t;

    frame_t frames [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        inclk   = 1'b0;
        done_in = 1'b0;
        in      = 8'h00;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_frame(input frame_t f);
        logic [7:0] bv;
        for (int b = 0; b < f.len; b++) begin
            bv      = f.data[8*(f.len-1-b) +: 8];
            inclk   = 1'b1;
            in      = bv;
            done_in = (b == f.len - 1);
            for (int d = 0; d < 4; d++) begin
                @(negedge clk);
                inclk   = 1'b0;
                done_in = 1'b0;
                chk("frame_outclk", {31'd0, outclk}, 32'd1);
                chk("frame_dibit", {30'd0, out}, {30'd0, bv[2*d +: 2]});
            end
        end
`ifdef FCS_APPEND_EN
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("fcs_outclk", {31'd0, outclk}, 32'd1);
            chk("fcs_idle", {31'd0, idle}, 32'd0);
            chk("fcs_dibit", {30'd0, out}, {30'd0, f.exp_crc[2*k +: 2]});
        end
`endif
        @(negedge clk);
        chk("done_pulse", {31'd0, done_out}, 32'd1);
        chk("done_crc", crc, f.exp_crc);
        chk("done_outclk", {31'd0, outclk}, 32'd0);
        @(negedge clk);
        chk("after_done_pulse", {31'd0, done_out}, 32'd0);
        chk("after_done_crc_init", crc, 32'h0);
        chk("after_done_idle", {31'd0, idle}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        logic [1:0]  t1_exp [4];
        logic [15:0] t6_exp;
        tests = 0;
        fails = 0;

        frames[0] = '{data: 72'h00,         len: 1, exp_crc: 32'hD202EF8D};
        frames[1] = '{data: 72'hFF,         len: 1, exp_crc: 32'hFF000000};
        frames[2] = '{data: "a",            len: 1, exp_crc: 32'hE8B7BE43};
        frames[3] = '{data: "abc",          len: 3, exp_crc: 32'h352441C2};
        frames[4] = '{data: "123456789",    len: 9, exp_crc: 32'hCBF43926};

        // Reset values while reset is held
        reset = 1'b1; inclk = 1'b0; done_in = 1'b0; in = 8'h00;
        #12;
        chk("rst_out", {30'd0, out}, 32'd0);
        chk("rst_outclk", {31'd0, outclk}, 32'd0);
        chk("rst_done_out", {31'd0, done_out}, 32'd0);
        chk("rst_idle", {31'd0, idle}, 32'd1);
        chk("rst_crc", crc, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Single byte 0xA5, no frame end
        t1_exp = '{2'b01, 2'b01, 2'b10, 2'b10};
        inclk = 1'b1; in = 8'hA5;
        for (int d = 0; d < 4; d++) begin
            @(negedge clk);
            inclk = 1'b0;
            chk("a5_outclk", {31'd0, outclk}, 32'd1);
            chk("a5_dibit", {30'd0, out}, {30'd0, t1_exp[d]});
            if (d == 1) chk("a5_busy_idle", {31'd0, idle}, 32'd0);
        end
        @(negedge clk);
        chk("a5_end_outclk", {31'd0, outclk}, 32'd0);
        chk("a5_end_out", {30'd0, out}, 32'd0);
        chk("a5_end_idle", {31'd0, idle}, 32'd1);

        // Frames back to back: each must restart from the initial CRC state
        do_reset();
        for (int f = 0; f < 5; f++) run_frame(frames[f]);

        // Empty frame
        done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
        chk("empty_done", {31'd0, done_out}, 32'd1);
        chk("empty_crc", crc, 32'h0);
        chk("empty_outclk", {31'd0, outclk}, 32'd0);
        @(negedge clk);
        chk("empty_done_clear", {31'd0, done_out}, 32'd0);

        // Reset during dibit 2 aborts at once
        do_reset();
        inclk = 1'b1; in = 8'hC3;
        @(negedge clk); inclk = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_pre_outclk", {31'd0, outclk}, 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_outclk", {31'd0, outclk}, 32'd0);
        chk("abort_crc", crc, 32'h0);
        chk("abort_idle", {31'd0, idle}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_no_partial", {31'd0, outclk}, 32'd0);
        inclk = 1'b1; in = 8'h5A;
        for (int d = 0; d < 4; d++) begin
            @(negedge clk);
            inclk = 1'b0;
            chk("post_abort_outclk", {31'd0, outclk}, 32'd1);
            chk("post_abort_dibit", {30'd0, out}, {30'd0, 8'h5A >> (2*d)} & 32'd3);
        end

        // Three strobes on consecutive cycles: first two stream, third dropped
        do_reset();
        t6_exp = 16'hE41B;
        inclk = 1'b1; in = 8'h1B;
        @(negedge clk);
        chk("b2b_d0", {30'd0, out}, {30'd0, t6_exp[1:0]});
        in = 8'hE4;
        @(negedge clk);
        chk("b2b_d1", {30'd0, out}, {30'd0, t6_exp[3:2]});
        in = 8'h77;
        for (int d = 2; d < 8; d++) begin
            @(negedge clk);
            inclk = 1'b0;
            chk("b2b_outclk", {31'd0, outclk}, 32'd1);
            chk("b2b_dibit", {30'd0, out}, {30'd0, t6_exp[2*d +: 2]});
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("drop_outclk", {31'd0, outclk}, 32'd0);
        end
        chk("drop_idle", {31'd0, idle}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
